// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter for the 16-bit datapath.
// Chooses PC+INC or a branch target each cycle, accepts resolved branches from
// decode with a hold-until-ack handshake, raises Flush for a fixed number of
// unstalled cycles after a taken branch, and supports Stall and Halt/Resume.
//
// Branch handshake: decode raises BranchReq (qualified by BranchTaken and
// BranchTarget) and holds all three stable until it sees BranchAck=1 in the
// same cycle; the accepting clock edge is the one at the end of that cycle.
// BranchAck is only ever given in RUN, never while Stall or Halt is high and
// never during reset, so a request outstanding at reset must be re-presented.

module pc_sequencer #(
    parameter int                 WIDTH        = 16,
    parameter logic [WIDTH-1:0]   RESET_PC     = '0,
    parameter int                 INC          = 1,
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Stall,
    input  logic             BranchReq,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Halt,
    input  logic             Resume,
    output logic [WIDTH-1:0] PC,
    output logic             PCSrc,
    output logic             PCWrite,
    output logic             BranchAck,
    output logic             Flush,
    output logic             Halted,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    // Flush length is carried in a 4-bit down-counter (valid range 1..15).
    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(INC);

    state_t           state;
    logic [3:0]       flush_count;
    logic [WIDTH-1:0] pc_next;
    logic             advance;

    assign dbg_state = state;

    // A cycle "advances" when we are sequencing and neither Stall nor Halt
    // holds us back; Stall outranks Halt, which outranks any branch.
    assign advance = Reset_n && (state != S_HALTED) && !Stall && !Halt;

    // Mux select, PC load enable and branch accept, all forced low in reset.
    always_comb begin
        PCSrc     = 1'b0;
        PCWrite   = 1'b0;
        BranchAck = 1'b0;
        if (advance) begin
            PCWrite = 1'b1;
            if (state == S_RUN && BranchReq) begin
                BranchAck = 1'b1;
                PCSrc     = BranchTaken;
            end
        end
    end

    // Next PC from the mux; the increment wraps modulo 2^WIDTH by design.
    always_comb begin
        pc_next = PC;
        if (PCWrite) begin
            if (PCSrc) begin
                pc_next = BranchTarget;
            end else begin
                pc_next = PC + PC_STEP;
            end
        end
    end

    // Sequencer FSM: PC, state, flush counter and the registered Flush/Halted.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            PC          <= RESET_PC;
            state       <= S_RUN;
            flush_count <= 4'd0;
            Flush       <= 1'b0;
            Halted      <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (Stall) begin
                        // Frozen: nothing moves.
                    end else if (Halt) begin
                        state       <= S_HALTED;
                        flush_count <= 4'd0;
                        Flush       <= 1'b0;
                        Halted      <= 1'b1;
                    end else begin
                        PC <= pc_next;
                        if (BranchAck && BranchTaken) begin
                            state       <= S_REDIRECT;
                            flush_count <= FLUSH_LOAD;
                            Flush       <= 1'b1;
                        end
                    end
                end

                S_REDIRECT: begin
                    if (Stall) begin
                        // Frozen: Flush and the counter hold, stretching the flush.
                    end else if (Halt) begin
                        state       <= S_HALTED;
                        flush_count <= 4'd0;
                        Flush       <= 1'b0;
                        Halted      <= 1'b1;
                    end else begin
                        PC          <= pc_next;
                        flush_count <= flush_count - 4'd1;
                        if (flush_count == 4'd1) begin
                            state <= S_RUN;
                            Flush <= 1'b0;
                        end
                    end
                end

                S_HALTED: begin
                    // Stall and Halt are ignored here; Resume returns to RUN
                    // without touching the PC on the resume edge.
                    if (Resume) begin
                        state  <= S_RUN;
                        Halted <= 1'b0;
                    end
                end

                default: begin
                    state       <= S_RUN;
                    flush_count <= 4'd0;
                    Flush       <= 1'b0;
                    Halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset, sequential fetch, taken and
// not-taken branches, requests held across REDIRECT, stall, wrap, halt/resume
// and asynchronous reset in the middle of a redirect.

module tb_pc_sequencer;

    localparam int W = 16;
    localparam logic [1:0] ST_RUN = 2'd0, ST_REDIR = 2'd1, ST_HALT = 2'd2;

    logic         CLK;
    logic         Reset_n;
    logic         Stall;
    logic         BranchReq;
    logic         BranchTaken;
    logic [W-1:0] BranchTarget;
    logic         Halt;
    logic         Resume;
    logic [W-1:0] PC;
    logic         PCSrc;
    logic         PCWrite;
    logic         BranchAck;
    logic         Flush;
    logic         Halted;
    logic [1:0]   dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    pc_sequencer #(
        .WIDTH(16), .RESET_PC(16'h0000), .INC(1), .FLUSH_CYCLES(2)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Stall(Stall), .BranchReq(BranchReq),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Halt(Halt),
        .Resume(Resume), .PC(PC), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .BranchAck(BranchAck), .Flush(Flush), .Halted(Halted),
        .dbg_state(dbg_state)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Overall time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Advance one clock; return 2 time units after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_branch(input logic req, input logic taken, input logic [W-1:0] tgt);
        BranchReq    = req;
        BranchTaken  = taken;
        BranchTarget = tgt;
    endtask

    initial begin
        Reset_n = 1'b0;
        Stall   = 1'b0;
        Halt    = 1'b0;
        Resume  = 1'b0;
        set_branch(1'b1, 1'b1, 16'hABCD);

        // ---- reset state: outputs low even with a request presented
        tick();
        #1;
        chk("rst_pc", 32'(PC), 32'h0000);
        chk("rst_pcwrite", 32'(PCWrite), 0);
        chk("rst_ack", 32'(BranchAck), 0);
        chk("rst_pcsrc", 32'(PCSrc), 0);
        chk("rst_flush", 32'(Flush), 0);
        chk("rst_halted", 32'(Halted), 0);
        chk("rst_state", 32'(dbg_state), ST_RUN);

        // ---- 1. release, idle sequencing
        set_branch(1'b0, 1'b0, 16'h0000);
        Reset_n = 1'b1;
        #1;
        chk("t1_pcwrite", 32'(PCWrite), 1);
        chk("t1_pcsrc", 32'(PCSrc), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t1_pc_seq", 32'(PC), 32'(i));
        end
        chk("t1_pcwrite_run", 32'(PCWrite), 1);
        for (int i = 0; i < 12; i++) tick();
        chk("t2_pc_pre", 32'(PC), 32'h0010);

        // ---- 2. taken branch to 1234
        set_branch(1'b1, 1'b1, 16'h1234);
        #1;
        chk("t2_ack", 32'(BranchAck), 1);
        chk("t2_pcsrc", 32'(PCSrc), 1);
        chk("t2_pcwrite", 32'(PCWrite), 1);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        chk("t2_pc_tgt", 32'(PC), 32'h1234);
        chk("t2_flush1", 32'(Flush), 1);
        chk("t2_state", 32'(dbg_state), ST_REDIR);
        tick();
        chk("t2_pc_1235", 32'(PC), 32'h1235);
        chk("t2_flush2", 32'(Flush), 1);
        tick();
        chk("t2_pc_1236", 32'(PC), 32'h1236);
        chk("t2_flush_off", 32'(Flush), 0);
        chk("t2_state_run", 32'(dbg_state), ST_RUN);

        // ---- 3. get to 0020 through a redirect, then a not-taken branch
        set_branch(1'b1, 1'b1, 16'h001E);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        chk("t3_pc_pre", 32'(PC), 32'h0020);
        set_branch(1'b1, 1'b0, 16'h7777);
        #1;
        chk("t3_ack", 32'(BranchAck), 1);
        chk("t3_pcsrc", 32'(PCSrc), 0);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        chk("t3_pc", 32'(PC), 32'h0021);
        chk("t3_flush", 32'(Flush), 0);

        // ---- 4. request held through REDIRECT
        set_branch(1'b1, 1'b1, 16'h0100);
        tick();
        set_branch(1'b1, 1'b1, 16'h0200);
        #1;
        chk("t4_pc_0100", 32'(PC), 32'h0100);
        chk("t4_ack_redir1", 32'(BranchAck), 0);
        chk("t4_pcsrc_redir", 32'(PCSrc), 0);
        tick();
        chk("t4_pc_0101", 32'(PC), 32'h0101);
        chk("t4_ack_redir2", 32'(BranchAck), 0);
        tick();
        chk("t4_pc_0102", 32'(PC), 32'h0102);
        chk("t4_ack_run", 32'(BranchAck), 1);
        chk("t4_pcsrc_run", 32'(PCSrc), 1);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        chk("t4_pc_0200", 32'(PC), 32'h0200);
        chk("t4_flush", 32'(Flush), 1);
        tick();
        tick();
        chk("t4_pc_0202", 32'(PC), 32'h0202);

        // ---- 5. stall during REDIRECT at 0040, then stall in RUN
        set_branch(1'b1, 1'b1, 16'h0040);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        Stall = 1'b1;
        #1;
        chk("t5_pcwrite_stall", 32'(PCWrite), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_pc_hold", 32'(PC), 32'h0040);
            chk("t5_flush_hold", 32'(Flush), 1);
        end
        Stall = 1'b0;
        tick();
        chk("t5_pc_0041", 32'(PC), 32'h0041);
        chk("t5_flush_after", 32'(Flush), 1);
        tick();
        chk("t5_pc_0042", 32'(PC), 32'h0042);
        chk("t5_flush_done", 32'(Flush), 0);
        Stall = 1'b1;
        set_branch(1'b1, 1'b1, 16'h5555);
        #1;
        chk("t5_ack_stall", 32'(BranchAck), 0);
        tick();
        chk("t5_pc_run_hold", 32'(PC), 32'h0042);
        chk("t5_state_run", 32'(dbg_state), ST_RUN);
        Stall = 1'b0;
        set_branch(1'b1, 1'b0, 16'h5555);
        #1;
        chk("t5_ack_release", 32'(BranchAck), 1);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        chk("t5_pc_0043", 32'(PC), 32'h0043);

        // ---- 6a. wrap FFFF -> 0000
        set_branch(1'b1, 1'b1, 16'hFFFE);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        tick();
        chk("t6_pc_ffff", 32'(PC), 32'hFFFF);
        tick();
        chk("t6_pc_wrap", 32'(PC), 32'h0000);

        // ---- 6b. halt at 0050
        set_branch(1'b1, 1'b1, 16'h004E);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        chk("t6_pc_0050", 32'(PC), 32'h0050);
        Halt = 1'b1;
        set_branch(1'b1, 1'b1, 16'h6666);
        #1;
        chk("t6_pcwrite_halt", 32'(PCWrite), 0);
        chk("t6_ack_halt", 32'(BranchAck), 0);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        chk("t6_halted", 32'(Halted), 1);
        chk("t6_pc_halt", 32'(PC), 32'h0050);
        Stall = 1'b1;
        tick();
        chk("t6_pc_halt2", 32'(PC), 32'h0050);
        chk("t6_state_halt", 32'(dbg_state), ST_HALT);
        Stall = 1'b0;
        Resume = 1'b1;
        #1;
        chk("t6_pcwrite_resume", 32'(PCWrite), 0);
        tick();
        chk("t6_halted_off", 32'(Halted), 0);
        chk("t6_state_resumed", 32'(dbg_state), ST_RUN);
        chk("t6_pc_resume_edge", 32'(PC), 32'h0050);
        Halt = 1'b0;
        Resume = 1'b0;
        tick();
        chk("t6_pc_0051", 32'(PC), 32'h0051);

        // ---- 6c. halt in REDIRECT drops the flush
        set_branch(1'b1, 1'b1, 16'h0300);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        Halt = 1'b1;
        tick();
        chk("t6c_halted", 32'(Halted), 1);
        chk("t6c_flush", 32'(Flush), 0);
        chk("t6c_pc", 32'(PC), 32'h0300);
        Halt = 1'b0;
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        tick();
        chk("t6c_pc_0301", 32'(PC), 32'h0301);
        chk("t6c_flush_run", 32'(Flush), 0);

        // ---- 6d. async reset in the middle of a redirect
        set_branch(1'b1, 1'b1, 16'h0400);
        tick();
        chk("t6d_flush_pre", 32'(Flush), 1);
        Reset_n = 1'b0;
        #1;
        chk("t6d_pc_rst", 32'(PC), 32'h0000);
        chk("t6d_flush_rst", 32'(Flush), 0);
        chk("t6d_ack_rst", 32'(BranchAck), 0);
        tick();
        set_branch(1'b0, 1'b0, 16'h0000);
        Reset_n = 1'b1;
        tick();
        chk("t6d_pc_after", 32'(PC), 32'h0001);
        chk("t6d_state_after", 32'(dbg_state), ST_RUN);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
